// File: rtl/synth_pkg.sv
// Shared widths, FSM encoding and event types for the synth voice path.
package synth_pkg;

    localparam int NOTE_W = 7;
    localparam int VEL_W  = 7;
    localparam int CH_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_COMMIT = 2'd2
    } fsm_state_e;

    typedef enum logic {
        EV_OFF = 1'b0,
        EV_ON  = 1'b1
    } ev_type_e;

    typedef struct packed {
        ev_type_e           ev;
        logic [NOTE_W-1:0]  note;
        logic [VEL_W-1:0]   vel;
    } voice_event_t;

    // A press with zero velocity is a release; a press always beats a release.
    function automatic ev_type_e classify(input logic pressed, input logic [VEL_W-1:0] vel);
        return (pressed && (vel != '0)) ? EV_ON : EV_OFF;
    endfunction

endpackage

// File: rtl/voice_rank_table.sv
// LRU rank table: rank 0 = most recently allocated, NUM_VOICES-1 = oldest.
module voice_rank_table #(
    parameter int NUM_VOICES = 4,
    parameter int IDX_W      = $clog2(NUM_VOICES)
) (
    input  logic             clk32,
    input  logic             nreset,
    input  logic             alloc,
    input  logic [IDX_W-1:0] target_idx,
    input  logic [IDX_W-1:0] lookup_idx,
    output logic [IDX_W-1:0] lookup_rank,
    output logic [IDX_W-1:0] oldest_idx
);

    logic [IDX_W-1:0] rank_q [NUM_VOICES];
    logic [IDX_W-1:0] target_rank;

    assign target_rank = rank_q[target_idx];
    assign lookup_rank = rank_q[lookup_idx];

    // Move the allocated voice to the front; voices that were newer than it age by one.
    always_ff @(posedge clk32 or negedge nreset) begin
        if (!nreset) begin
            // NOTE: this small array is reset because its contents are architectural state (a valid permutation), unlike a plain data RAM.
            for (int i = 0; i < NUM_VOICES; i++) rank_q[i] <= IDX_W'(i);
        end else if (alloc) begin
            // NOTE: non-blocking assignments here so every element sees the pre-update target_rank.
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (IDX_W'(i) == target_idx)
                    rank_q[i] <= '0;
                else if (rank_q[i] < target_rank)
                    rank_q[i] <= rank_q[i] + 1'b1;
            end
        end
    end

    // Find the voice holding the highest rank.
    always_comb begin
        oldest_idx = '0;
        for (int i = 0; i < NUM_VOICES; i++)
            if (rank_q[i] == IDX_W'(NUM_VOICES - 1)) oldest_idx = IDX_W'(i);
    end

endmodule

// File: rtl/midi_voice_alloc.sv
// Polyphonic voice allocator: pending buffer, IDLE/SCAN/COMMIT FSM, voice register file.
module midi_voice_alloc
    import synth_pkg::*;
#(
    parameter int          NUM_VOICES   = 4,
    parameter logic [15:0] CHANNEL_MASK = 16'hFFFF
) (
    input  logic                         clk32,
    input  logic                         nreset,
    input  logic                         note_pressed,
    input  logic                         note_released,
    input  logic [NOTE_W-1:0]            note,
    input  logic [VEL_W-1:0]             velocity,
    input  logic [CH_W-1:0]              channel,
    input  logic                         panic,
    output logic [NOTE_W*NUM_VOICES-1:0] voice_note,
    output logic [VEL_W*NUM_VOICES-1:0]  voice_vel,
    output logic [NUM_VOICES-1:0]        voice_gate,
    output logic [NUM_VOICES-1:0]        voice_trig,
    output logic                         busy,
    output logic                         overflow
);

    localparam int IDX_W = $clog2(NUM_VOICES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    fsm_state_e       state;
    voice_event_t     pend, cur_ev;
    logic             pend_valid;
    logic [IDX_W-1:0] scan_idx, match_idx, free_idx, old_idx, target_idx;
    logic             found_match, found_free;
    logic [IDX_W-1:0] rank_lookup, oldest_idx;
    logic [NOTE_W-1:0] scan_note;
    logic             ev_take, consume, alloc;

    assign ev_take   = (note_pressed | note_released) && CHANNEL_MASK[channel] && !panic;
    assign consume   = (state == ST_IDLE) && pend_valid;
    assign alloc     = (state == ST_COMMIT) && (cur_ev.ev == EV_ON) && !panic;
    assign scan_note = voice_note[int'(scan_idx)*NOTE_W +: NOTE_W];

    voice_rank_table #(
        .NUM_VOICES (NUM_VOICES),
        .IDX_W      (IDX_W)
    ) u_rank (
        .clk32       (clk32),
        .nreset      (nreset),
        .alloc       (alloc),
        .target_idx  (target_idx),
        .lookup_idx  (scan_idx),
        .lookup_rank (rank_lookup),
        .oldest_idx  (oldest_idx)
    );

    // Commit target priority: held same note, then lowest free voice, then oldest.
    always_comb begin
        // NOTE: default assigned first so no path leaves target_idx unassigned (no latch).
        target_idx = old_idx;
        if (found_match)     target_idx = match_idx;
        else if (found_free) target_idx = free_idx;
    end

    // One-entry pending buffer with sticky overflow; panic flushes both.
    always_ff @(posedge clk32 or negedge nreset) begin
        if (!nreset) begin
            pend_valid <= 1'b0;
            pend       <= '0;
            overflow   <= 1'b0;
        end else if (panic) begin
            pend_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (consume) pend_valid <= 1'b0;
            if (ev_take) begin
                if (pend_valid) begin
                    overflow <= 1'b1;
                end else begin
                    pend_valid <= 1'b1;
                    pend       <= '{ev: classify(note_pressed, velocity), note: note, vel: velocity};
                end
            end
        end
    end

    // Allocator FSM with the voice register file and registered outputs.
    always_ff @(posedge clk32 or negedge nreset) begin
        if (!nreset) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            cur_ev      <= '0;
            scan_idx    <= '0;
            match_idx   <= '0;
            free_idx    <= '0;
            old_idx     <= '0;
            found_match <= 1'b0;
            found_free  <= 1'b0;
            voice_note  <= '0;
            voice_vel   <= '0;
            voice_gate  <= '0;
            voice_trig  <= '0;
        end else if (panic) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            voice_gate <= '0;
            voice_trig <= '0;
        end else begin
            voice_trig <= '0;
            case (state)
                ST_IDLE: begin
                    if (pend_valid) begin
                        cur_ev      <= pend;
                        state       <= ST_SCAN;
                        busy        <= 1'b1;
                        scan_idx    <= '0;
                        found_match <= 1'b0;
                        found_free  <= 1'b0;
                        old_idx     <= oldest_idx;
                    end
                end
                ST_SCAN: begin
                    if (!found_match && voice_gate[scan_idx] && (scan_note == cur_ev.note)) begin
                        found_match <= 1'b1;
                        match_idx   <= scan_idx;
                    end
                    if (!found_free && !voice_gate[scan_idx]) begin
                        found_free <= 1'b1;
                        free_idx   <= scan_idx;
                    end
                    if (rank_lookup == LAST_IDX) old_idx <= scan_idx;
                    if (scan_idx == LAST_IDX) state <= ST_COMMIT;
                    else                      scan_idx <= scan_idx + 1'b1;
                end
                ST_COMMIT: begin
                    if (cur_ev.ev == EV_ON) begin
                        voice_note[int'(target_idx)*NOTE_W +: NOTE_W] <= cur_ev.note;
                        voice_vel[int'(target_idx)*VEL_W +: VEL_W]    <= cur_ev.vel;
                        voice_gate[target_idx] <= 1'b1;
                        voice_trig[target_idx] <= 1'b1;
                    end else if (found_match) begin
                        voice_gate[match_idx] <= 1'b0;
                    end
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
